// File: rtl/ifetch_queue_bp_if.sv
// ============================================================================
// ifetch_queue_bp_if
// Memory, decoder, flush and branch-update signals for the fetch unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ifetch_queue_bp_if;
  // memory controller side
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_instr_i;
  // decoder side
  logic        dec_valid_o;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic        dec_pred_o;
  logic        dec_ready_i;
  // ROB side
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        bht_upd_i;
  logic [31:0] bht_upd_pc_i;
  logic        bht_upd_tk_i;

  // master: the fetch unit
  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_done_i, mem_instr_i,
    output dec_valid_o, dec_instr_o, dec_pc_o, dec_pred_o,
    input  dec_ready_i,
    input  flush_i, flush_pc_i,
    input  bht_upd_i, bht_upd_pc_i, bht_upd_tk_i
  );

  // slave: memory controller, decoder and ROB seen as one environment
  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_done_i, mem_instr_i,
    input  dec_valid_o, dec_instr_o, dec_pc_o, dec_pred_o,
    output dec_ready_i,
    output flush_i, flush_pc_i,
    output bht_upd_i, bht_upd_pc_i, bht_upd_tk_i
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_queue_bp.sv
// ============================================================================
// ifetch_queue_bp
// Instruction fetch: direct-mapped I-cache, fetch queue to the decoder,
// static JAL redirect and 2-bit bimodal prediction for conditional branches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ifetch_queue_bp #(
  parameter int ICACHE_IDX_W = 5,
  parameter int FQ_DEPTH_W   = 3,
  parameter int BHT_IDX_W    = 6
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        rdy,
  ifetch_queue_bp_if.master bus
);

  localparam int FQ_DEPTH = 1 << FQ_DEPTH_W;
  localparam int IC_LINES = 1 << ICACHE_IDX_W;
  localparam int BHT_N    = 1 << BHT_IDX_W;
  localparam int TAG_W    = 30 - ICACHE_IDX_W;
  localparam logic [FQ_DEPTH_W:0] FQ_FULL = (FQ_DEPTH_W+1)'(FQ_DEPTH);
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        mem_req, mem_req_nx;
  logic [31:0] mem_addr, mem_addr_nx;

  // fetch queue
  logic [31:0]           q_instr [FQ_DEPTH];
  logic [31:0]           q_pc    [FQ_DEPTH];
  logic [FQ_DEPTH-1:0]   q_pred;
  logic [FQ_DEPTH_W-1:0] head, tail;
  logic [FQ_DEPTH_W:0]   count;

  // I-cache and branch history
  logic [IC_LINES-1:0]   ic_valid;
  logic [TAG_W-1:0]      ic_tag  [IC_LINES];
  logic [31:0]           ic_data [IC_LINES];
  logic [1:0]            bht     [BHT_N];

  logic [ICACHE_IDX_W-1:0] ic_idx, fill_idx;
  logic [BHT_IDX_W-1:0]    bht_idx, upd_idx;
  logic                    ic_hit;
  logic [31:0]             fetch_word, j_imm, b_imm, next_pc;
  logic                    next_pred;
  logic [1:0]              bht_ctr;
  logic                    push, pop, fill, q_clear;
  logic                    unused_bits;

  assign ic_idx   = pc[ICACHE_IDX_W+1:2];
  assign fill_idx = mem_addr[ICACHE_IDX_W+1:2];
  assign bht_idx  = pc[BHT_IDX_W+1:2];
  assign upd_idx  = bus.bht_upd_pc_i[BHT_IDX_W+1:2];
  assign ic_hit   = ic_valid[ic_idx] && (ic_tag[ic_idx] == pc[31:ICACHE_IDX_W+2]);
  assign unused_bits = &{1'b0, bus.bht_upd_pc_i[31:BHT_IDX_W+2], bus.bht_upd_pc_i[1:0]};

  // Decode the word being fetched this cycle (cache on hits, memory on fills) into next PC / prediction
  always_comb begin
    fetch_word = (state == IDLE) ? ic_data[ic_idx] : bus.mem_instr_i;
    j_imm = {{11{fetch_word[31]}}, fetch_word[31], fetch_word[19:12],
             fetch_word[20], fetch_word[30:21], 1'b0};
    b_imm = {{19{fetch_word[31]}}, fetch_word[31], fetch_word[7],
             fetch_word[30:25], fetch_word[11:8], 1'b0};
    bht_ctr   = bht[bht_idx];
    next_pc   = pc + 32'd4;
    next_pred = 1'b0;
    if (fetch_word[6:0] == OP_JAL) begin
      next_pc   = pc + j_imm;
      next_pred = 1'b1;
    end else if ((fetch_word[6:0] == OP_BR) && bht_ctr[1]) begin
      next_pc   = pc + b_imm;
      next_pred = 1'b1;
    end
  end

  // Fetch FSM next-state logic: flush overrides normal fetch; DRAIN swallows a stale response
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    mem_req_nx  = 1'b0;
    mem_addr_nx = mem_addr;
    push        = 1'b0;
    fill        = 1'b0;
    q_clear     = 1'b0;
    pop         = (count != '0) && bus.dec_ready_i;
    if (bus.flush_i) begin
      pc_nx   = bus.flush_pc_i;
      q_clear = 1'b1;
      pop     = 1'b0;
      if (state != IDLE) begin
        if (bus.mem_done_i) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < FQ_FULL) begin
            if (ic_hit) begin
              push  = 1'b1;
              pc_nx = next_pc;
            end else begin
              mem_req_nx  = 1'b1;
              mem_addr_nx = pc;
              state_nx    = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (bus.mem_done_i) begin
            fill     = 1'b1;
            push     = 1'b1;
            pc_nx    = next_pc;
            state_nx = IDLE;
          end
        end
        DRAIN: begin
          if (bus.mem_done_i) begin
            fill     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM, PC and memory request registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (rdy) begin
      state    <= state_nx;
      pc       <= pc_nx;
      mem_req  <= mem_req_nx;
      mem_addr <= mem_addr_nx;
    end
  end

  // Circular fetch queue; entry storage needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (q_clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_instr[tail] <= fetch_word;
          q_pc[tail]    <= pc;
          q_pred[tail]  <= next_pred;
          tail          <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // I-cache line fill from the returning memory word, indexed by the held request address
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_valid <= '0;
    end else if (rdy && fill) begin
      ic_valid[fill_idx] <= 1'b1;
      ic_tag[fill_idx]   <= mem_addr[31:ICACHE_IDX_W+2];
      ic_data[fill_idx]  <= bus.mem_instr_i;
    end
  end

  // Bimodal counters: saturating update on branch commit; lookups this cycle see the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (rdy && bus.bht_upd_i) begin
      if (bus.bht_upd_tk_i) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.dec_valid_o = (count != '0);
  assign bus.dec_instr_o = bus.dec_valid_o ? q_instr[head] : 32'd0;
  assign bus.dec_pc_o    = bus.dec_valid_o ? q_pc[head]    : 32'd0;
  assign bus.dec_pred_o  = bus.dec_valid_o ? q_pred[head]  : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue_bp.sv
// ============================================================================
// tb_ifetch_queue_bp
// Randomised bench for ifetch_queue_bp with a program-level reference model
// and an expected-entry scoreboard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ifetch_queue_bp;

  localparam int K_SEQ = 0;
  localparam int K_JAL = 1;
  localparam int K_BR  = 2;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  ifetch_queue_bp_if bus();

  ifetch_queue_bp dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // program image: word, control-flow kind and branch/jump offset per word slot
  logic [31:0] prog_word [256];
  int          prog_kind [256];
  int          prog_off  [256];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  // scoreboard of expected queue contents, head first
  ent_t sbq[$];

  // reference model state
  logic [31:0] m_pc, m_addr;
  logic        m_req;
  int          m_mode;            // 0 fetching, 1 waiting for own miss, 2 discarding stale response
  bit          c_valid [32];
  logic [29:0] c_word  [32];      // word address held in each cache line
  int          bht     [64];
  bit          armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off, input logic [4:0] rd);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int off, input logic [14:0] regs);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], regs[14:10], regs[9:5], regs[4:2], o[4:1], o[11], 7'b1100011};
  endfunction

  // Build a random program of short forward/backward jumps and branches
  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      prog_off[i] = (int'($urandom_range(0, 32)) - 16) * 4;
      case ($urandom_range(0, 7))
        4: begin prog_kind[i] = K_JAL; prog_word[i] = enc_jal(prog_off[i], r[11:7]); end
        5, 6: begin prog_kind[i] = K_BR; prog_word[i] = enc_br(prog_off[i], r[26:12]); end
        7: begin prog_kind[i] = K_SEQ; prog_word[i] = {r[31:7], 7'b1100111}; end
        default: begin prog_kind[i] = K_SEQ; prog_word[i] = {r[31:7], 7'b0010011}; end
      endcase
    end
    prog_kind[0]  = K_SEQ; prog_word[0]  = 32'h0000_0013;
    prog_kind[4]  = K_JAL; prog_off[4]   = 8;  prog_word[4]  = 32'h0080_00EF;
    prog_kind[16] = K_BR;  prog_off[16]  = 16; prog_word[16] = enc_br(16, 15'h0);
  end

  function automatic bit m_hit(input logic [31:0] a);
    return c_valid[a[6:2]] && (c_word[a[6:2]] == a[31:2]);
  endfunction

  task automatic m_fill(input logic [31:0] a);
    c_valid[a[6:2]] = 1'b1;
    c_word[a[6:2]]  = a[31:2];
  endtask

  // Deliver the word at m_pc to the expected queue and follow the predicted path
  task automatic m_fetch();
    int  i;
    bit  tk;
    ent_t e;
    i  = int'(m_pc[9:2]);
    tk = (prog_kind[i] == K_JAL) || ((prog_kind[i] == K_BR) && (bht[m_pc[7:2]] >= 2));
    e.instr = prog_word[i];
    e.pc    = m_pc;
    e.pred  = tk;
    sbq.push_back(e);
    m_pc = tk ? (m_pc + 32'(prog_off[i])) : (m_pc + 32'd4);
  endtask

  // One clock of the reference model, using the inputs the DUT will sample at the next edge
  task automatic m_step();
    int cnt;
    if (rst) begin
      m_pc = '0; m_addr = '0; m_req = 1'b0; m_mode = 0;
      sbq.delete();
      for (int i = 0; i < 32; i++) c_valid[i] = 1'b0;
      for (int i = 0; i < 64; i++) bht[i] = 1;
      armed = 1;
      return;
    end
    if (!rdy) return;
    cnt   = sbq.size();
    m_req = 1'b0;
    if (bus.flush_i) begin
      if (m_mode != 0 && bus.mem_done_i) m_fill(m_addr);
      m_mode = (m_mode == 0 || bus.mem_done_i) ? 0 : 2;
      sbq.delete();
      m_pc = bus.flush_pc_i;
    end else begin
      if (cnt != 0 && bus.dec_ready_i) begin
        void'(sbq.pop_front());
        pops++;
      end
      case (m_mode)
        0: if (cnt < 8) begin
             if (m_hit(m_pc)) m_fetch();
             else begin m_req = 1'b1; m_addr = m_pc; m_mode = 1; end
           end
        1: if (bus.mem_done_i) begin m_fill(m_addr); m_fetch(); m_mode = 0; end
        default: if (bus.mem_done_i) begin m_fill(m_addr); m_mode = 0; end
      endcase
    end
    if (bus.bht_upd_i) begin
      if (bus.bht_upd_tk_i) begin
        if (bht[bus.bht_upd_pc_i[7:2]] < 3) bht[bus.bht_upd_pc_i[7:2]]++;
      end else begin
        if (bht[bus.bht_upd_pc_i[7:2]] > 0) bht[bus.bht_upd_pc_i[7:2]]--;
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    m_step();
  end

  // Monitor: compare what the DUT presents against the scoreboard head and model request
  always @(negedge clk) begin
    if (armed) begin
      check("mem_req",   32'(bus.mem_req_o), 32'(m_req));
      check("mem_addr",  bus.mem_addr_o, m_addr);
      check("dec_valid", 32'(bus.dec_valid_o), 32'(sbq.size() != 0));
      if (sbq.size() != 0) begin
        check("dec_pc",    bus.dec_pc_o, sbq[0].pc);
        check("dec_instr", bus.dec_instr_o, sbq[0].instr);
        check("dec_pred",  32'(bus.dec_pred_o), 32'(sbq[0].pred));
      end else begin
        check("dec_pc_idle",    bus.dec_pc_o, 32'd0);
        check("dec_instr_idle", bus.dec_instr_o, 32'd0);
        check("dec_pred_idle",  32'(bus.dec_pred_o), 32'd0);
      end
    end
  end

  // Stimulus and memory responder, changing inputs shortly after each rising edge
  initial begin
    bit          pend;
    int          lat;
    int          phase;
    logic [31:0] paddr;
    pend = 0; lat = 0; paddr = '0;
    bus.mem_done_i   = 1'b0;
    bus.mem_instr_i  = '0;
    bus.dec_ready_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.flush_pc_i   = '0;
    bus.bht_upd_i    = 1'b0;
    bus.bht_upd_pc_i = '0;
    bus.bht_upd_tk_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    rdy = 1'b1;
    bus.dec_ready_i = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #2;
      phase = (cyc < 80) ? 0 : ((cyc / 250) % 4);
      case (phase)
        0: begin
          rdy = 1'b1;
          bus.dec_ready_i = 1'b1;
          bus.flush_i = (cyc >= 80) && ($urandom_range(0, 99) < 2);
        end
        1: begin
          rdy = 1'b1;
          bus.dec_ready_i = ($urandom_range(0, 99) < 12);
          bus.flush_i = ($urandom_range(0, 99) < 2);
        end
        2: begin
          rdy = ($urandom_range(0, 99) < 60);
          bus.dec_ready_i = ($urandom_range(0, 99) < 70);
          bus.flush_i = ($urandom_range(0, 99) < 4);
        end
        default: begin
          rdy = ($urandom_range(0, 99) < 90);
          bus.dec_ready_i = ($urandom_range(0, 99) < 60);
          bus.flush_i = ($urandom_range(0, 99) < 12);
        end
      endcase
      bus.flush_pc_i   = ($urandom_range(0, 3) == 0) ? 32'h100 : (32'($urandom_range(0, 255)) << 2);
      bus.bht_upd_i    = (cyc >= 80) && ($urandom_range(0, 99) < 30);
      bus.bht_upd_pc_i = ($urandom_range(0, 1) == 0) ? 32'h40 : (32'($urandom_range(0, 255)) << 2);
      bus.bht_upd_tk_i = ($urandom_range(0, 99) < 65);
      // memory: one outstanding read, returned only in an enabled cycle
      if (pend) begin
        if (lat > 0) lat--;
      end else if (bus.mem_req_o) begin
        pend  = 1;
        paddr = bus.mem_addr_o;
        lat   = (cyc < 80) ? 2 : int'($urandom_range(1, 4));
      end
      bus.mem_done_i = 1'b0;
      if (pend && lat == 0 && rdy) begin
        bus.mem_done_i  = 1'b1;
        bus.mem_instr_i = prog_word[paddr[9:2]];
        pend = 0;
      end
    end
    @(negedge clk);
    #2;
    check("pop_progress", 32'(pops > 200), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
